etcpu_mmio_timer: RTL and testbench
===================================

# etcpu_mmio_timer

Memory-mapped timer/compare peripheral on the core's main-memory data interface (chip-select, write-enable, address, write data). It decodes a 32-byte window, holds a prescaled 32-bit up-counter with compare match, a sticky match flag and a level interrupt. Read data is returned combinationally in the same cycle, as the core's memory-access stage requires. The system-level read mux selects this data when `sel` is high.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: window base; bits [4:0] ignored.
- `PRESC_W`, default 16: prescaler width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `mem_cs` in 1: chip-select from the core.
- `mem_wen` in 1: write enable; 1 = write, 0 = read.
- `mem_addr` in 32: byte address.
- `mem_dat_in` in 32: write data (memory POV input).
- `sel` out 1: combinational address hit, `mem_cs & (mem_addr[31:5]==BASE_ADDR[31:5])`.
- `rd_dat` out 32: combinational read data; 0 unless `sel & !mem_wen`.
- `irq` out 1: `flag & CTRL.irq_en`, driven from registers only.

## Operation
- Register map, word offset `mem_addr[4:2]`; `mem_addr[1:0]` ignored:
  - 0x00 CTRL [2:0]: bit0 `en`, bit1 `autoreload`, bit2 `irq_en`. Other bits read 0.
  - 0x04 PRESC [PRESC_W-1:0].
  - 0x08 COUNT [31:0], read/write.
  - 0x0C COMPARE [31:0].
  - 0x10 STATUS: bit0 `flag`. Write 1 clears it; write 0 has no effect.
  - 0x14–0x1C: read 0, writes ignored.
- Write: occurs when `sel & mem_wen`. The register updates at the next rising edge.
- Prescaler:
  - Internal `pcnt` [PRESC_W-1:0] runs while `en`=1.
  - When `pcnt==PRESC`: `tick`=1 and `pcnt` returns to 0. Otherwise `pcnt` increments.
  - `pcnt` is forced to 0 in any of these cases: `en`=0, a write to PRESC, or a write to CTRL.
- On `tick`:
  - If `COUNT==COMPARE`, `flag` is set. COUNT then goes to 0 if `autoreload`=1, otherwise to COUNT+1.
  - If `COUNT!=COMPARE`, COUNT goes to COUNT+1.
  - Increment is modulo 2^32: 0xFFFF_FFFF → 0, with no flag unless COMPARE matched.
- Priority for simultaneous events:
  - A software write to COUNT overrides the tick update in the same cycle. The match test still uses the old COUNT, so `flag` can still set.
  - A flag set overrides a write-1-to-clear in the same cycle; `flag` stays 1.
  - A write to COMPARE takes effect for matching from the next cycle.
- `en`=0: COUNT holds, and `flag` holds until it is cleared.
- Reset mid-operation: all state returns to reset values at the next edge. Any write in that cycle is discarded.

## Timing
- Reset values:
  - CTRL=0, PRESC=0, COUNT=0, COMPARE=0xFFFF_FFFF, flag=0, `pcnt`=0.
  - Therefore `irq`=0 and `rd_dat`=0 when not selected.
- Read latency is 0 cycles. `rd_dat` shows register values as they were before the current edge. A read and a write to the same register in one cycle cannot occur (a single port).
- Tick period is PRESC+1 cycles.
- Start-up: CTRL.en written at edge E0. With PRESC=N, the first COUNT increment is visible after edge E0+N+1.
- `flag` and `irq` rise at the same edge at which the matching tick updates COUNT. No added pipeline delay.
- `sel` is purely combinational; there is no handshake or stall, and every access completes in its own cycle.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst` for 2 cycles, then read all offsets.
  - Required: CTRL/PRESC/COUNT/STATUS = 0, COMPARE = 0xFFFF_FFFF, 0x14 = 0, `irq`=0.
  - An access outside the window gives `sel`=0 and `rd_dat`=0.
- Prescale:
  - Stimulus: PRESC=3, then CTRL=1.
  - Required: COUNT reads 1, 2, 3 at 4, 8 and 12 cycles after the CTRL write edge.
  - With PRESC=0, COUNT increments every cycle.
- Compare with autoreload:
  - Stimulus: COMPARE=5, PRESC=0, CTRL=7.
  - Required: COUNT goes 0..5, then 0. `flag`=1 and `irq`=1 at the edge where COUNT returns to 0. The period is 6 cycles.
  - Writing STATUS=1 drops `irq` at the next edge.
- Simultaneous set/clear: a W1C to STATUS in the same cycle as a matching tick leaves `flag`=1.
- Count write versus tick:
  - Stimulus: with `en`=1 and PRESC=0, write COUNT=0x100.
  - Required: COUNT reads 0x100 after the edge, not old+1. COUNT is 0x101 one cycle later.
- Wrap and reset:
  - Stimulus: COUNT=0xFFFF_FFFE, COMPARE=0x10, `autoreload`=0.
  - Required: COUNT goes FFFF_FFFF, 0, 1 and `flag` stays 0.
  - Asserting `rst` while counting returns all registers to their reset values one edge later.

Source files
------------

// File: rtl/etcpu_mmio_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : etcpu_mmio_timer_if
// Purpose  : Core main-memory data bus as seen by an MMIO peripheral.
//            Single-cycle access with no handshake. The core drives chip-select,
//            write-enable, address and write data. The peripheral returns an
//            address-hit indication and combinational read data.
// Signals  : mem_cs     - chip-select from the core
//            mem_wen    - 1 = write, 0 = read
//            mem_addr   - byte address
//            mem_dat_in - write data (memory point of view)
//            sel        - peripheral address hit (drives the system read mux)
//            rd_dat     - combinational read data
// Revision : 1.0 - initial release
// ============================================================================
interface etcpu_mmio_timer_if;
    logic        mem_cs;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dat_in;
    logic        sel;
    logic [31:0] rd_dat;

    modport master (
        output mem_cs, mem_wen, mem_addr, mem_dat_in,
        input  sel, rd_dat
    );

    modport slave (
        input  mem_cs, mem_wen, mem_addr, mem_dat_in,
        output sel, rd_dat
    );
endinterface
`default_nettype wire

// File: rtl/etcpu_mmio_timer.sv
`default_nettype none
// ============================================================================
// Module   : etcpu_mmio_timer
// Purpose  : Memory-mapped timer/compare peripheral. It decodes a 32-byte
//            window and holds a prescaled 32-bit up-counter with a compare
//            match, a sticky match flag and a level interrupt. Read data is
//            returned in the same cycle.
// Ports    : clk  - clock
//            rst  - synchronous active-high reset
//            bus  - slave side of the core data bus (see etcpu_mmio_timer_if)
//            irq  - level interrupt, flag & CTRL.irq_en
// Map      : 0x00 CTRL {irq_en, autoreload, en}, 0x04 PRESC, 0x08 COUNT,
//            0x0C COMPARE, 0x10 STATUS {flag} (write 1 to clear),
//            0x14-0x1C read as zero
// Revision : 1.0 - initial release
// ============================================================================
module etcpu_mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          PRESC_W   = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    etcpu_mmio_timer_if.slave  bus,
    output logic               irq
);

    localparam logic [2:0] c_off_ctrl    = 3'd0;
    localparam logic [2:0] c_off_presc   = 3'd1;
    localparam logic [2:0] c_off_count   = 3'd2;
    localparam logic [2:0] c_off_compare = 3'd3;
    localparam logic [2:0] c_off_status  = 3'd4;

    logic [2:0]         r_ctrl;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_pcnt;
    logic [31:0]        r_count;
    logic [31:0]        r_compare;
    logic               r_flag;

    logic        w_sel;
    logic        w_wr;
    logic [2:0]  w_off;
    logic        w_wr_ctrl;
    logic        w_wr_presc;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_en;
    logic        w_tick;
    logic        w_match;
    logic [31:0] w_rd_dat;
    logic        w_unused_bits;

    // Address decode: only bits [31:5] take part in the window match
    assign w_sel        = bus.mem_cs & (bus.mem_addr[31:5] == BASE_ADDR[31:5]);
    assign w_wr         = w_sel & bus.mem_wen;
    assign w_off        = bus.mem_addr[4:2];
    assign w_wr_ctrl    = w_wr & (w_off == c_off_ctrl);
    assign w_wr_presc   = w_wr & (w_off == c_off_presc);
    assign w_wr_count   = w_wr & (w_off == c_off_count);
    assign w_wr_compare = w_wr & (w_off == c_off_compare);
    assign w_wr_status  = w_wr & (w_off == c_off_status);

    // Byte-lane bits and upper write-data bits beyond the register widths
    assign w_unused_bits = ^{bus.mem_addr[1:0], bus.mem_dat_in};

    assign w_en    = r_ctrl[0];
    assign w_tick  = w_en & (r_pcnt == r_presc);
    // The match uses the pre-edge COUNT and COMPARE, so a same-cycle write to
    // either register does not affect this tick's match
    assign w_match = (r_count == r_compare);

    // Prescaler: restarts on any CTRL/PRESC write so the first tick after a
    // (re)configuration always lands PRESC+1 cycles later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (!w_en || w_wr_presc || w_wr_ctrl || w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl    <= '0;
            r_presc   <= '0;
            r_compare <= 32'hFFFF_FFFF;
        end else begin
            if (w_wr_ctrl)    r_ctrl    <= bus.mem_dat_in[2:0];
            if (w_wr_presc)   r_presc   <= bus.mem_dat_in[PRESC_W-1:0];
            if (w_wr_compare) r_compare <= bus.mem_dat_in;
        end
    end

    // A software write wins over the tick update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= bus.mem_dat_in;
        end else if (w_tick) begin
            r_count <= (w_match && r_ctrl[1]) ? 32'd0 : r_count + 32'd1;
        end
    end

    // A set from a match wins over a same-cycle write-1-to-clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag <= 1'b0;
        end else if (w_tick && w_match) begin
            r_flag <= 1'b1;
        end else if (w_wr_status && bus.mem_dat_in[0]) begin
            r_flag <= 1'b0;
        end
    end

    always_comb begin
        w_rd_dat = 32'd0;
        if (w_sel && !bus.mem_wen) begin
            case (w_off)
                c_off_ctrl:    w_rd_dat = {29'd0, r_ctrl};
                c_off_presc:   w_rd_dat = 32'(r_presc);
                c_off_count:   w_rd_dat = r_count;
                c_off_compare: w_rd_dat = r_compare;
                c_off_status:  w_rd_dat = {31'd0, r_flag};
                default:       w_rd_dat = 32'd0;
            endcase
        end
    end

    assign bus.sel    = w_sel;
    assign bus.rd_dat = w_rd_dat;
    assign irq        = r_flag & r_ctrl[2];

endmodule
`default_nettype wire

// File: tb/tb_etcpu_mmio_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_etcpu_mmio_timer
// Purpose  : Self-checking bench for etcpu_mmio_timer. Directed bus accesses.
//            Every read pushes its expected value to a scoreboard queue. The
//            value is popped and compared when the read data is sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_etcpu_mmio_timer;

    localparam logic [31:0] c_base    = 32'hFFFF_0000;
    localparam logic [31:0] c_ctrl    = c_base + 32'h00;
    localparam logic [31:0] c_presc   = c_base + 32'h04;
    localparam logic [31:0] c_count   = c_base + 32'h08;
    localparam logic [31:0] c_compare = c_base + 32'h0C;
    localparam logic [31:0] c_status  = c_base + 32'h10;
    localparam logic [31:0] c_rsvd    = c_base + 32'h14;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic irq;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    etcpu_mmio_timer_if bus ();

    etcpu_mmio_timer #(
        .BASE_ADDR (c_base),
        .PRESC_W   (16)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .irq (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // Read one register. The expected value goes to the scoreboard at drive
    // time and is compared at the following falling edge. The access occupies
    // exactly one clock cycle.
    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_val,
                      input string tag, input bit chk_irq, input logic exp_irq);
        exp_t e;
        bus.mem_cs   = 1'b1;
        bus.mem_wen  = 1'b0;
        bus.mem_addr = addr;
        sb.push_back('{tag, exp_val});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        assert (bus.rd_dat === e.val) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", e.tag, bus.rd_dat, e.val);
        end
        checks++;
        assert (bus.sel === 1'b1) else begin
            errors++;
            $error("FAIL %s_sel: observed %b required 1", e.tag, bus.sel);
        end
        if (chk_irq) begin
            checks++;
            assert (irq === exp_irq) else begin
                errors++;
                $error("FAIL %s_irq: observed %b required %b", e.tag, irq, exp_irq);
            end
        end
        @(posedge clk);
        #1;
        bus.mem_cs = 1'b0;
    endtask

    // Write one register. It updates at the next rising edge and returns 1ns
    // after that edge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.mem_cs     = 1'b1;
        bus.mem_wen    = 1'b1;
        bus.mem_addr   = addr;
        bus.mem_dat_in = data;
        @(posedge clk);
        #1;
        bus.mem_cs  = 1'b0;
        bus.mem_wen = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.mem_cs     = 1'b0;
        bus.mem_wen    = 1'b0;
        bus.mem_addr   = 32'd0;
        bus.mem_dat_in = 32'd0;
        rst            = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state of every offset
        rd(c_ctrl,    32'd0,         "rst_ctrl",    1'b1, 1'b0);
        rd(c_presc,   32'd0,         "rst_presc",   1'b0, 1'b0);
        rd(c_count,   32'd0,         "rst_count",   1'b0, 1'b0);
        rd(c_compare, 32'hFFFF_FFFF, "rst_compare", 1'b0, 1'b0);
        rd(c_status,  32'd0,         "rst_status",  1'b0, 1'b0);
        rd(c_rsvd,    32'd0,         "rst_rsvd",    1'b0, 1'b0);
        rd(c_compare + 32'd1, 32'hFFFF_FFFF, "byte_lane_ignored", 1'b0, 1'b0);

        // Access outside the window
        bus.mem_cs   = 1'b1;
        bus.mem_wen  = 1'b0;
        bus.mem_addr = 32'h0000_1008;
        @(negedge clk);
        checks++;
        assert (bus.sel === 1'b0) else begin
            errors++;
            $error("FAIL outside_sel: observed %b required 0", bus.sel);
        end
        checks++;
        assert (bus.rd_dat === 32'd0) else begin
            errors++;
            $error("FAIL outside_rd: observed %h required 0", bus.rd_dat);
        end
        @(posedge clk);
        #1;
        bus.mem_cs = 1'b0;

        // Prescale by 4: CTRL write edge is E0, increments after E0+4/8/12
        wr(c_presc, 32'd3);
        wr(c_ctrl,  32'd1);
        idle(4);
        rd(c_count, 32'd1, "presc3_c1", 1'b0, 1'b0);
        idle(3);
        rd(c_count, 32'd2, "presc3_c2", 1'b0, 1'b0);
        idle(3);
        rd(c_count, 32'd3, "presc3_c3", 1'b0, 1'b0);

        // PRESC=0: increments every cycle
        wr(c_ctrl,  32'd0);
        wr(c_presc, 32'd0);
        wr(c_count, 32'd0);
        wr(c_ctrl,  32'd1);
        rd(c_count, 32'd0, "presc0_c0", 1'b0, 1'b0);
        rd(c_count, 32'd1, "presc0_c1", 1'b0, 1'b0);
        rd(c_count, 32'd2, "presc0_c2", 1'b0, 1'b0);

        // Compare with autoreload: 0..5 then 0 with flag and irq
        wr(c_ctrl,    32'd0);
        wr(c_count,   32'd0);
        wr(c_compare, 32'd5);
        wr(c_ctrl,    32'd7);
        for (int k = 0; k < 6; k++) begin
            rd(c_count, k, $sformatf("ar_count%0d", k), 1'b1, 1'b0);
        end
        rd(c_count, 32'd0, "ar_reload", 1'b1, 1'b1);
        // W1C clears at the next edge (no match at that edge)
        wr(c_status, 32'd1);
        rd(c_status, 32'd0, "w1c_clear", 1'b1, 1'b0);
        rd(c_count,  32'd3, "ar_period", 1'b0, 1'b0);
        idle(1);
        // W1C at the same edge as the matching tick: flag stays set
        wr(c_status, 32'd1);
        rd(c_status, 32'd1, "set_beats_clear", 1'b1, 1'b1);
        rd(c_count,  32'd1, "ar_after_second", 1'b0, 1'b0);

        // COUNT write overrides a same-cycle tick
        wr(c_count, 32'h100);
        rd(c_count, 32'h100, "cwr_override", 1'b0, 1'b0);
        rd(c_count, 32'h101, "cwr_next", 1'b0, 1'b0);

        // Wrap without match and without autoreload
        wr(c_ctrl,    32'd0);
        wr(c_status,  32'd1);
        wr(c_compare, 32'h10);
        wr(c_count,   32'hFFFF_FFFE);
        wr(c_ctrl,    32'd1);
        rd(c_count, 32'hFFFF_FFFE, "wrap_fe", 1'b0, 1'b0);
        rd(c_count, 32'hFFFF_FFFF, "wrap_ff", 1'b0, 1'b0);
        rd(c_count, 32'd0,         "wrap_00", 1'b0, 1'b0);
        rd(c_count, 32'd1,         "wrap_01", 1'b0, 1'b0);
        rd(c_status, 32'd0,        "wrap_noflag", 1'b0, 1'b0);

        // Reset while counting, with a write in the reset cycle discarded
        wr(c_ctrl, 32'd7);
        rst            = 1'b1;
        bus.mem_cs     = 1'b1;
        bus.mem_wen    = 1'b1;
        bus.mem_addr   = c_count;
        bus.mem_dat_in = 32'h55;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.mem_cs  = 1'b0;
        bus.mem_wen = 1'b0;
        rd(c_ctrl,    32'd0,         "mrst_ctrl",    1'b1, 1'b0);
        rd(c_presc,   32'd0,         "mrst_presc",   1'b0, 1'b0);
        rd(c_count,   32'd0,         "mrst_count",   1'b0, 1'b0);
        rd(c_compare, 32'hFFFF_FFFF, "mrst_compare", 1'b0, 1'b0);
        rd(c_status,  32'd0,         "mrst_status",  1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
